// File: rtl/vga_line_fetch_scheduler.sv
// Raster position counters for 640x480@60 with one-line-ahead framebuffer fetch scheduling.
// Define VGA_UNDERRUN_COUNT_EN to add the saturating underrun_count output.
module vga_line_fetch_scheduler #(
  parameter int X_RES   = 640,
  parameter int Y_RES   = 480,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int LINE_W  = 10
) (
  input  logic              clk25,
  input  logic              rst_n,
  input  logic              enable,
  output logic [LINE_W-1:0] pixel_position_x,
  output logic [LINE_W-1:0] pixel_position_y,
  output logic              frame_start,
  output logic              fetch_req,
  output logic [LINE_W-1:0] fetch_line,
  input  logic              fetch_ack,
  input  logic              fetch_done,
  output logic              underrun
`ifdef VGA_UNDERRUN_COUNT_EN
  ,
  output logic [7:0]        underrun_count
`endif
);

  localparam logic [LINE_W-1:0] X_TRIG   = LINE_W'(X_RES - 1);
  localparam logic [LINE_W-1:0] X_LAST   = LINE_W'(H_TOTAL - 1);
  localparam logic [LINE_W-1:0] Y_LAST   = LINE_W'(V_TOTAL - 1);
  localparam logic [LINE_W-1:0] Y_ACTIVE = LINE_W'(Y_RES);

  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

  state_t            r_state, w_next_state;
  logic              r_started, r_frame_start, r_underrun;
  logic [LINE_W-1:0] r_x, r_y, r_fetch_line;
  logic              w_first, w_advance, w_line_end, w_line_enter, w_frame_enter;
  logic              w_target_valid, w_trigger, w_start_fetch, w_underrun_set;
  logic [LINE_W-1:0] w_x_next, w_y_next, w_y_inc, w_target;

  // The first enabled cycle after reset only loads (0,0) and arms the line-0 prefetch.
  always_comb begin
    w_first    = enable && !r_started;
    w_advance  = enable && r_started;
    w_line_end = (r_x == X_LAST);
    w_x_next   = w_line_end ? '0 : r_x + LINE_W'(1);
    w_y_inc    = r_y + LINE_W'(1);
    if (!w_line_end)
      w_y_next = r_y;
    else if (r_y == Y_LAST)
      w_y_next = '0;
    else
      w_y_next = w_y_inc;
    w_line_enter   = w_advance && w_line_end;
    w_frame_enter  = w_first || (w_line_enter && (w_y_next == '0));
    w_target_valid = (r_y == Y_LAST) || (w_y_inc < Y_ACTIVE);
    w_target       = w_first ? '0 : ((r_y == Y_LAST) ? '0 : w_y_inc);
    w_trigger      = w_advance && (r_x == X_TRIG) && w_target_valid;
    w_start_fetch  = (r_state == IDLE) && (w_first || w_trigger);
    w_underrun_set = (r_state != IDLE) &&
                     (w_trigger || (w_line_enter && (w_y_next < Y_ACTIVE)));
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Handshake progress ignores enable so an outstanding fetch can always complete.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: if (w_start_fetch) w_next_state = REQ;
      REQ: begin
        if (fetch_ack && fetch_done) w_next_state = IDLE;
        else if (fetch_ack)          w_next_state = BUSY;
      end
      BUSY: if (fetch_done) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    fetch_req = (r_state == REQ);
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_started     <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_frame_start <= 1'b0;
    end else if (enable) begin
      r_started     <= 1'b1;
      r_frame_start <= w_frame_enter;
      if (r_started) begin
        r_x <= w_x_next;
        r_y <= w_y_next;
      end
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_line <= '0;
    end else if (w_start_fetch) begin
      r_fetch_line <= w_target;
    end
  end

  // A new underrun in the frame_start cycle must survive the frame clear.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun <= 1'b0;
    end else if (w_underrun_set) begin
      r_underrun <= 1'b1;
    end else if (w_frame_enter) begin
      r_underrun <= 1'b0;
    end
  end

`ifdef VGA_UNDERRUN_COUNT_EN
  logic [7:0] r_underrun_count;

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun_count <= '0;
    end else if (w_underrun_set && (r_underrun_count != 8'hFF)) begin
      r_underrun_count <= r_underrun_count + 8'd1;
    end
  end

  assign underrun_count = r_underrun_count;
`endif

  assign pixel_position_x = r_x;
  assign pixel_position_y = r_y;
  assign frame_start      = r_frame_start;
  assign fetch_line       = r_fetch_line;
  assign underrun         = r_underrun;

endmodule

// File: tb/tb_vga_line_fetch_scheduler.sv
// Randomized bench for vga_line_fetch_scheduler with a reduced raster and an arithmetic reference model.
// The bench also acts as the memory arbiter, with randomized ack/done latencies.
module tb_vga_line_fetch_scheduler;

  localparam int XR    = 32;
  localparam int YR    = 9;
  localparam int HT    = 48;
  localparam int VT    = 12;
  localparam int LW    = 10;
  localparam int FRAME = HT * VT;

  logic          clk25 = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          fetch_ack;
  logic          fetch_done;
  logic [LW-1:0] pixel_position_x;
  logic [LW-1:0] pixel_position_y;
  logic          frame_start;
  logic          fetch_req;
  logic [LW-1:0] fetch_line;
  logic          underrun;
`ifdef VGA_UNDERRUN_COUNT_EN
  logic [7:0]    underrun_count;
`endif

  vga_line_fetch_scheduler #(
    .X_RES(XR), .Y_RES(YR), .H_TOTAL(HT), .V_TOTAL(VT), .LINE_W(LW)
  ) dut (
    .clk25(clk25),
    .rst_n(rst_n),
    .enable(enable),
    .pixel_position_x(pixel_position_x),
    .pixel_position_y(pixel_position_y),
    .frame_start(frame_start),
    .fetch_req(fetch_req),
    .fetch_line(fetch_line),
    .fetch_ack(fetch_ack),
    .fetch_done(fetch_done),
    .underrun(underrun)
`ifdef VGA_UNDERRUN_COUNT_EN
    ,
    .underrun_count(underrun_count)
`endif
  );

  always #20 clk25 = ~clk25;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: enabled-cycle count since the frame origin plus an outstanding-fetch record.
  int mT;
  bit mStarted, mFs, mOut, mAcc, mUnder;
  int mLine, mCount;

  int ackWait, doneWait, maxAck, maxDone;
  bit stallAck;

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    cmp("pixel_x",     32'(pixel_position_x), 32'(mT % HT));
    cmp("pixel_y",     32'(pixel_position_y), 32'((mT / HT) % VT));
    cmp("frame_start", 32'(frame_start),      32'(mFs));
    cmp("fetch_req",   32'(fetch_req),        32'(mOut && !mAcc));
    cmp("fetch_line",  32'(fetch_line),       32'(mLine));
    cmp("underrun",    32'(underrun),         32'(mUnder));
`ifdef VGA_UNDERRUN_COUNT_EN
    cmp("underrun_count", 32'(underrun_count), 32'(mCount));
`endif
  endtask

  task automatic modelReset();
    mT = 0; mStarted = 0; mFs = 0; mOut = 0; mAcc = 0;
    mUnder = 0; mLine = 0; mCount = 0;
    ackWait = 0; doneWait = 0;
  endtask

  task automatic issue(input int line);
    mOut    = 1;
    mAcc    = 0;
    mLine   = line;
    ackWait = $urandom_range(0, maxAck);
  endtask

  task automatic modelStep(input bit en, input bit ack, input bit done);
    bit wasOut, wasAcc, trig, setU;
    int x, y, nx, ny, tgt;
    wasOut = mOut;
    wasAcc = mAcc;
    if (wasOut && !wasAcc && ack) begin
      if (done) mOut = 0;
      else begin
        mAcc     = 1;
        doneWait = $urandom_range(0, maxDone);
      end
    end else if (wasOut && wasAcc && done) begin
      mOut = 0;
      mAcc = 0;
    end
    if (en) begin
      if (!mStarted) begin
        mStarted = 1;
        mFs      = 1;
        issue(0);
      end else begin
        x    = mT % HT;
        y    = (mT / HT) % VT;
        trig = (x == XR - 1) && ((y == VT - 1) || (y + 1 < YR));
        tgt  = (y == VT - 1) ? 0 : y + 1;
        mT++;
        nx   = mT % HT;
        ny   = (mT / HT) % VT;
        mFs  = (nx == 0) && (ny == 0);
        setU = wasOut && (trig || ((nx == 0) && (ny < YR)));
        if (trig && !wasOut) issue(tgt);
        if (setU) begin
          mUnder = 1;
          if (mCount < 255) mCount++;
        end else if (mFs) begin
          mUnder = 0;
        end
      end
    end
  endtask

  // Drives one cycle of arbiter behaviour from the model's view of the handshake.
  task automatic applyStimulus(input bit en);
    enable     = en;
    fetch_ack  = 1'b0;
    fetch_done = 1'b0;
    if (mOut && !mAcc) begin
      if (!stallAck) begin
        if (ackWait == 0) begin
          fetch_ack = 1'b1;
          if ($urandom_range(0, 3) == 0) fetch_done = 1'b1;
        end else begin
          ackWait--;
        end
      end
    end else if (mOut && mAcc) begin
      if (doneWait == 0) fetch_done = 1'b1;
      else doneWait--;
      if ($urandom_range(0, 7) == 0) fetch_ack = 1'b1;
    end else begin
      if ($urandom_range(0, 15) == 0) fetch_ack = 1'b1;
      if ($urandom_range(0, 15) == 0) fetch_done = 1'b1;
    end
    @(posedge clk25);
    modelStep(en, fetch_ack, fetch_done);
    @(negedge clk25);
  endtask

  task automatic runCycles(input int n, input bit dropEnable);
    for (int i = 0; i < n; i++) begin
      applyStimulus(dropEnable ? ($urandom_range(0, 15) != 0) : 1'b1);
      checkOutput();
    end
  endtask

  initial begin
    bit reached;
    rst_n = 1'b0; enable = 1'b0; fetch_ack = 1'b0; fetch_done = 1'b0;
    maxAck = 2; maxDone = 10; stallAck = 0;
    modelReset();
    repeat (2) @(negedge clk25);
    checkOutput();

    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0);
      checkOutput();
    end

    $display("[TB] fetches completing within blanking");
    runCycles(3 * FRAME, 1'b1);

    $display("[TB] long fetch latencies");
    maxAck = 20; maxDone = 30;
    runCycles(2 * FRAME, 1'b1);

    $display("[TB] arbiter withholding ack");
    stallAck = 1;
    runCycles(6500, 1'b0);
    stallAck = 0; ackWait = 0; maxAck = 2; maxDone = 10;
    runCycles(2 * FRAME, 1'b0);

    $display("[TB] reset while a fetch is in progress");
    maxDone = 60;
    reached = 0;
    for (int i = 0; i < 3000 && !reached; i++) begin
      applyStimulus(1'b1);
      checkOutput();
      if (mOut && mAcc && ((mT / HT) % VT) >= 3) reached = 1;
    end
    cmp("busy_reached", 32'(reached), 32'd1);
    #5;
    rst_n = 1'b0; fetch_ack = 1'b0; fetch_done = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(negedge clk25);
    checkOutput();
    rst_n = 1'b1;
    maxDone = 10;
    runCycles(2 * FRAME, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
